rpn_operand_stack_ctrl: RTL and testbench
=========================================

Name: rpn_operand_stack_ctrl

Overview:
Sequential RPN front-end for the 8-bit ALU. It holds the operand stack and accepts push or operator commands through a valid/ready handshake. For each operator it pops two operands, drives the combinational ALU (adder, subtractor, multiplier, divider), and pushes the registered result back. It also detects stack overflow, stack underflow and divide-by-zero before any ALU result is committed.

Parameters:
DEPTH, 8, number of stack entries (power of two, 2..16)
WIDTH, 8, operand and result width in bits

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command (IDLE only)
cmd_is_op  in  1  1 = operator command, 0 = push cmd_data
cmd_data  in  WIDTH  literal to push
cmd_op  in  3  operator code (see package)
alu_a  out  WIDTH  ALU first operand (deeper entry)
alu_b  out  WIDTH  ALU second operand (top entry; divisor for DIV/MOD)
alu_sel  out  3  operator forwarded to the ALU
alu_q  in  WIDTH  ALU primary result (sum/diff/product low byte/quotient)
alu_r  in  WIDTH  ALU remainder (valid for DIV/MOD)
top  out  WIDTH  current top of stack, 0 when empty
count  out  $clog2(DEPTH)+1  number of valid entries
done  out  1  one-cycle pulse when a command completes, with or without error
err  out  2  error code of the last completed command

Behaviour:
- Reset is asynchronous and active-low. All stack entries, alu_a, alu_b, alu_sel, top, count, done and err clear to 0. The FSM goes to IDLE with cmd_ready=1.
- A command is accepted on the rising edge where cmd_valid and cmd_ready are both 1. cmd_ready is 1 only in IDLE.
- err is cleared on each accepted command and updated in the cycle that done pulses.
- Operator codes: ADD=0, SUB=1, MUL=2, DIV=3, MOD=4, DUP=5, SWAP=6, DROP=7.

Push (cmd_is_op=0):
- Completes in the acceptance cycle. done is high in the next cycle, where count and top already reflect the push.
- If count==DEPTH: the stack is unchanged and err=OVF.

ALU operators (ADD..MOD), 4 cycles total. States IDLE -> LOAD -> EXEC -> WB -> IDLE:
- LOAD:
  - If count<2: go to WB with err=UNF and the stack unchanged.
  - Otherwise register alu_a=stack[count-2], alu_b=stack[count-1] and alu_sel=cmd_op.
- EXEC:
  - The ALU is combinational; sample alu_q/alu_r into the internal result register.
  - DIV/MOD with alu_b==0: set err=DIVZ and do not use the ALU outputs.
- WB:
  - Without error: pop 2 and push the result, so count decreases by 1. The result is alu_q for ADD/SUB/MUL/DIV and alu_r for MOD.
  - With error: the stack is unchanged.
  - Pulse done, then return to IDLE.
- ADD and SUB wrap modulo 2^WIDTH and set no error. MUL keeps the low WIDTH bits.

Stack operators (DUP, SWAP, DROP):
- Go IDLE -> WB directly, finishing in 2 cycles.
- DUP: needs count>=1 and count<DEPTH. count==0 gives UNF; a full stack gives OVF.
- SWAP: needs count>=2, else UNF.
- DROP: needs count>=1, else UNF.

Other rules:
- top is a registered view of stack[count-1] and is updated in the same cycle as count.
- An asynchronous reset in any state aborts the command immediately with no partial write. done does not pulse after reset.
- alu_a, alu_b and alu_sel hold their values outside LOAD/EXEC, so the ALU inputs do not toggle needlessly.
- Error codes: NONE=0, OVF=1, UNF=2, DIVZ=3.

Decomposition:
- Package rpn_pkg holds:
  - operator code constants (shared with the ALU mux select)
  - error code constants
  - FSM state enumeration (IDLE, LOAD, EXEC, WB)
- Sub-module rpn_stack_regs is the natural split. It is the DEPTH x WIDTH register file with a count pointer and operations push, pop2_push, dup, swap and drop.
- The FSM and error checks stay in the top block.

Test Plan:
- Push 7, push 3, op DIV -> done at the 4th cycle after acceptance, top=2, count=1, err=NONE. Repeat with MOD -> top=1.
- Push 3, push 5, op SUB -> top=0xFE (wrap), count=1, err=NONE. Push 20, push 13, op MUL -> top=0x04.
- Push 200, push 0, op DIV -> err=DIVZ, count=2, top=0, stack contents unchanged.
- 8 pushes (1..8) then a 9th push -> err=OVF, count=8, top=8. Then DROP x8 and one more DROP -> err=UNF, count=0, top=0.
- Push 9, op ADD -> err=UNF, count=1, top=9. Then DUP -> top=9, count=2. Push 4, SWAP -> top=9, the entry below is 4.
- Push 6, push 2, op DIV, assert rst_n=0 during EXEC -> count=0, top=0, err=0, no done pulse, cmd_ready=1 after release.

Source files
------------

// File: rtl/rpn_pkg.sv
// rpn_pkg: shared operator, error and state encodings for the RPN stack controller
package rpn_pkg;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_MOD  = 3'd4;
  localparam logic [2:0] OP_DUP  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_DROP = 3'd7;
  localparam logic [1:0] E_NONE  = 2'd0;
  localparam logic [1:0] E_OVF   = 2'd1;
  localparam logic [1:0] E_UNF   = 2'd2;
  localparam logic [1:0] E_DIVZ  = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_WB} state_e;
  typedef enum logic [2:0] {STK_NOP, STK_PUSH, STK_POP2_PUSH, STK_DUP, STK_SWAP, STK_DROP} stk_op_e;
  function automatic logic is_div(input logic [2:0] op);
    return op == OP_DIV || op == OP_MOD;
  endfunction
endpackage

// File: rtl/rpn_stack_regs.sv
// rpn_stack_regs: DEPTH x WIDTH operand stack with count pointer and registered top view
//   i_op/i_data : stack operation applied at the next rising edge (caller guarantees legality)
//   o_a, o_b    : entries count-2 and count-1 (ALU operand sources)
//   o_top       : registered stack[count-1], 0 when empty
//   o_count     : number of valid entries
module rpn_stack_regs
  import rpn_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  stk_op_e          i_op,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [WIDTH-1:0] o_top,
  output logic [CW-1:0]    o_count
);
  logic [DEPTH-1:0][WIDTH-1:0] r_mem, w_mem;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [WIDTH-1:0] r_top;
  logic [AW-1:0] w_i0, w_i1, w_i2, w_it;
  // Indices wrap modulo DEPTH, so a full stack's write slot aliases entry 0 harmlessly.
  assign w_i0 = r_cnt[AW-1:0];
  assign w_i1 = w_i0 - AW'(1);
  assign w_i2 = w_i0 - AW'(2);
  assign w_it = w_cnt[AW-1:0] - AW'(1);
  assign o_a = r_mem[w_i2];
  assign o_b = r_mem[w_i1];
  assign o_top = r_top;
  assign o_count = r_cnt;
  always_comb begin
    w_mem = r_mem;
    w_cnt = r_cnt;
    case (i_op)
      STK_PUSH: begin
        w_mem[w_i0] = i_data;
        w_cnt = r_cnt + CW'(1);
      end
      STK_POP2_PUSH: begin
        w_mem[w_i2] = i_data;
        w_cnt = r_cnt - CW'(1);
      end
      STK_DUP: begin
        w_mem[w_i0] = r_mem[w_i1];
        w_cnt = r_cnt + CW'(1);
      end
      STK_SWAP: begin
        w_mem[w_i1] = r_mem[w_i2];
        w_mem[w_i2] = r_mem[w_i1];
      end
      STK_DROP: w_cnt = r_cnt - CW'(1);
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mem <= '0;
      r_cnt <= '0;
      r_top <= '0;
    end else begin
      r_mem <= w_mem;
      r_cnt <= w_cnt;
      r_top <= w_cnt == '0 ? '0 : w_mem[w_it];
    end
endmodule

// File: rtl/rpn_operand_stack_ctrl.sv
// rpn_operand_stack_ctrl: RPN command front-end driving an external combinational ALU
//   cmd_valid/cmd_ready/cmd_is_op/cmd_data/cmd_op : command handshake (ready only in IDLE)
//   alu_a/alu_b/alu_sel -> ALU, alu_q/alu_r <- ALU : operands held outside LOAD/EXEC
//   top/count : registered stack view;  done/err : completion pulse and last error code
module rpn_operand_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_is_op,
  input  logic [WIDTH-1:0]       cmd_data,
  input  logic [2:0]             cmd_op,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [2:0]             alu_sel,
  input  logic [WIDTH-1:0]       alu_q,
  input  logic [WIDTH-1:0]       alu_r,
  output logic [WIDTH-1:0]       top,
  output logic [$clog2(DEPTH):0] count,
  output logic                   done,
  output logic [1:0]             err
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e r_state, w_state;
  logic [2:0] r_op;
  logic [1:0] r_perr, w_perr, r_err, w_fin_err, w_wb_err;
  logic [WIDTH-1:0] r_res, r_alu_a, r_alu_b, w_stk_data, w_sa, w_sb;
  logic [2:0] r_alu_sel;
  logic r_done, w_fin, w_accept, w_full, w_empty, w_lt2;
  stk_op_e w_stk_op, w_wb_op;
  logic [CW-1:0] w_count;
  rpn_stack_regs #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_stack (
    .clk(clk), .rst_n(rst_n), .i_op(w_stk_op), .i_data(w_stk_data),
    .o_a(w_sa), .o_b(w_sb), .o_top(top), .o_count(w_count)
  );
  assign count = w_count;
  assign cmd_ready = r_state == S_IDLE;
  assign w_accept = cmd_valid && cmd_ready;
  assign w_full = w_count == CW'(DEPTH);
  assign w_empty = w_count == '0;
  assign w_lt2 = w_count < CW'(2);
  assign alu_a = r_alu_a;
  assign alu_b = r_alu_b;
  assign alu_sel = r_alu_sel;
  assign done = r_done;
  assign err = r_err;
  // Stack operators are checked at WB; ALU operators carry the error found in LOAD/EXEC.
  assign w_wb_err = r_op == OP_DUP  ? (w_empty ? E_UNF : w_full ? E_OVF : E_NONE)
                  : r_op == OP_SWAP ? (w_lt2 ? E_UNF : E_NONE)
                  : r_op == OP_DROP ? (w_empty ? E_UNF : E_NONE)
                  : r_perr;
  assign w_wb_op = w_wb_err != E_NONE ? STK_NOP
                 : r_op == OP_DUP     ? STK_DUP
                 : r_op == OP_SWAP    ? STK_SWAP
                 : r_op == OP_DROP    ? STK_DROP
                 : STK_POP2_PUSH;
  always_comb begin
    w_state = r_state;
    w_stk_op = STK_NOP;
    w_stk_data = r_res;
    w_fin = 1'b0;
    w_fin_err = E_NONE;
    w_perr = r_perr;
    case (r_state)
      S_IDLE: if (cmd_valid) begin
        w_perr = E_NONE;
        if (cmd_is_op) w_state = cmd_op >= OP_DUP ? S_WB : S_LOAD;
        else begin
          w_fin = 1'b1;
          w_fin_err = w_full ? E_OVF : E_NONE;
          w_stk_op = w_full ? STK_NOP : STK_PUSH;
          w_stk_data = cmd_data;
        end
      end
      S_LOAD: begin
        w_state = w_lt2 ? S_WB : S_EXEC;
        w_perr = w_lt2 ? E_UNF : E_NONE;
      end
      S_EXEC: begin
        w_state = S_WB;
        w_perr = is_div(r_op) && r_alu_b == '0 ? E_DIVZ : E_NONE;
      end
      S_WB: begin
        w_state = S_IDLE;
        w_fin = 1'b1;
        w_fin_err = w_wb_err;
        w_stk_op = w_wb_op;
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op <= '0;
      r_perr <= E_NONE;
      r_err <= E_NONE;
      r_done <= 1'b0;
      r_res <= '0;
      r_alu_a <= '0;
      r_alu_b <= '0;
      r_alu_sel <= '0;
    end else begin
      r_state <= w_state;
      r_perr <= w_perr;
      r_done <= w_fin;
      if (w_accept) r_op <= cmd_op;
      if (w_fin) r_err <= w_fin_err;
      else if (w_accept) r_err <= E_NONE;
      if (r_state == S_LOAD && !w_lt2) begin
        r_alu_a <= w_sa;
        r_alu_b <= w_sb;
        r_alu_sel <= r_op;
      end
      if (r_state == S_EXEC) r_res <= r_op == OP_MOD ? alu_r : alu_q;
    end
endmodule

// File: tb/tb_rpn_operand_stack_ctrl.sv
// tb_rpn_operand_stack_ctrl: directed and random commands checked against a queue-based stack model
module tb_rpn_operand_stack_ctrl;
  import rpn_pkg::*;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_is_op = 1'b0, cmd_ready, done;
  logic [7:0] cmd_data = '0, alu_a, alu_b, alu_q, alu_r, top;
  logic [2:0] cmd_op = '0, alu_sel;
  logic [3:0] count;
  logic [1:0] err;
  int n_pass = 0, n_tot = 0, done_cnt = 0;
  logic [7:0] mq[$];
  rpn_operand_stack_ctrl #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_op(cmd_is_op), .cmd_data(cmd_data), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_q(alu_q), .alu_r(alu_r),
    .top(top), .count(count), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (done === 1'b1) done_cnt++;
  // Behavioural ALU attached to the controller.
  always_comb begin
    alu_q = alu_sel == OP_SUB ? alu_a - alu_b
          : alu_sel == OP_MUL ? alu_a * alu_b
          : alu_sel == OP_DIV ? (alu_b == 0 ? 8'hFF : alu_a / alu_b)
          : alu_a + alu_b;
    alu_r = alu_b == 0 ? alu_a : alu_a % alu_b;
  end
  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
  endtask
  // Reference model: applies a command to the queue and predicts err/latency/ALU operands.
  task automatic model(input logic isop, input logic [2:0] op, input logic [7:0] d,
                       output logic [1:0] e, output int l, output logic ac,
                       output logic [7:0] ea, output logic [7:0] eb);
    logic [7:0] a, b, r;
    int n;
    n = mq.size();
    e = E_NONE; ac = 1'b0; ea = '0; eb = '0; l = 2;
    if (!isop) begin
      l = 1;
      if (n == DEPTH) e = E_OVF;
      else mq.push_back(d);
    end else if (op <= OP_MOD) begin
      l = 4;
      if (n < 2) begin
        e = E_UNF;
        l = 3;
      end else begin
        b = mq[n-1];
        a = mq[n-2];
        ac = 1'b1; ea = a; eb = b;
        if ((op == OP_DIV || op == OP_MOD) && b == 0) e = E_DIVZ;
        else begin
          case (op)
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_MUL: r = a * b;
            OP_DIV: r = a / b;
            default: r = a % b;
          endcase
          void'(mq.pop_back());
          void'(mq.pop_back());
          mq.push_back(r);
        end
      end
    end else if (op == OP_DUP) begin
      if (n == 0) e = E_UNF;
      else if (n == DEPTH) e = E_OVF;
      else mq.push_back(mq[n-1]);
    end else if (op == OP_SWAP) begin
      if (n < 2) e = E_UNF;
      else begin
        b = mq[n-1];
        mq[n-1] = mq[n-2];
        mq[n-2] = b;
      end
    end else begin
      if (n == 0) e = E_UNF;
      else void'(mq.pop_back());
    end
  endtask
  task automatic run(input string tag, input logic isop, input logic [2:0] op, input logic [7:0] d);
    logic [1:0] e;
    int l, cyc;
    logic ac;
    logic [7:0] ea, eb;
    @(negedge clk);
    chk(tag, "ready", cmd_ready, 1);
    model(isop, op, d, e, l, ac, ea, eb);
    cmd_valid = 1'b1; cmd_is_op = isop; cmd_op = op; cmd_data = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 8) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk(tag, "latency", cyc, l);
    chk(tag, "err", err, e);
    chk(tag, "count", count, mq.size());
    chk(tag, "top", top, mq.size() > 0 ? mq[$] : 8'h00);
    if (ac) begin
      chk(tag, "alu_a", alu_a, ea);
      chk(tag, "alu_b", alu_b, eb);
      chk(tag, "alu_sel", alu_sel, op);
    end
    @(posedge clk);
    #1 chk(tag, "done_pulse", done, 0);
  endtask
  task automatic drain();
    while (mq.size() > 0) run("drain", 1'b1, OP_DROP, 8'h00);
  endtask
  initial begin
    int dc;
    #12;
    chk("reset", "count", count, 0);
    chk("reset", "top", top, 0);
    chk("reset", "err", err, 0);
    chk("reset", "done", done, 0);
    chk("reset", "alu_a", alu_a, 0);
    chk("reset", "alu_sel", alu_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("reset", "ready", cmd_ready, 1);
    run("div_p7", 1'b0, 3'd0, 8'd7);
    run("div_p3", 1'b0, 3'd0, 8'd3);
    run("div", 1'b1, OP_DIV, 8'd0);
    chk("div", "top_is_2", top, 8'd2);
    run("mod_p7", 1'b0, 3'd0, 8'd7);
    run("mod_p3", 1'b0, 3'd0, 8'd3);
    run("mod", 1'b1, OP_MOD, 8'd0);
    chk("mod", "top_is_1", top, 8'd1);
    drain();
    run("sub_p3", 1'b0, 3'd0, 8'd3);
    run("sub_p5", 1'b0, 3'd0, 8'd5);
    run("sub", 1'b1, OP_SUB, 8'd0);
    chk("sub", "wrap", top, 8'hFE);
    drain();
    run("mul_p20", 1'b0, 3'd0, 8'd20);
    run("mul_p13", 1'b0, 3'd0, 8'd13);
    run("mul", 1'b1, OP_MUL, 8'd0);
    chk("mul", "low_byte", top, 8'h04);
    drain();
    run("divz_p200", 1'b0, 3'd0, 8'd200);
    run("divz_p0", 1'b0, 3'd0, 8'd0);
    run("divz", 1'b1, OP_DIV, 8'd0);
    chk("divz", "code", err, E_DIVZ);
    run("divz_drop", 1'b1, OP_DROP, 8'd0);
    chk("divz", "below_kept", top, 8'd200);
    drain();
    for (int i = 1; i <= 8; i++) run("fill", 1'b0, 3'd0, 8'(i));
    run("ovf_push", 1'b0, 3'd0, 8'd99);
    chk("ovf", "code", err, E_OVF);
    run("ovf_dup", 1'b1, OP_DUP, 8'd0);
    for (int i = 0; i < 8; i++) run("drop", 1'b1, OP_DROP, 8'd0);
    run("unf_drop", 1'b1, OP_DROP, 8'd0);
    chk("unf_drop", "code", err, E_UNF);
    run("unf_dup", 1'b1, OP_DUP, 8'd0);
    run("unf_p9", 1'b0, 3'd0, 8'd9);
    run("unf_add", 1'b1, OP_ADD, 8'd0);
    run("unf_swap", 1'b1, OP_SWAP, 8'd0);
    run("dup", 1'b1, OP_DUP, 8'd0);
    run("swap_p4", 1'b0, 3'd0, 8'd4);
    run("swap", 1'b1, OP_SWAP, 8'd0);
    chk("swap", "top_is_9", top, 8'd9);
    run("swap_drop", 1'b1, OP_DROP, 8'd0);
    chk("swap", "below_is_4", top, 8'd4);
    drain();
    run("rst_p6", 1'b0, 3'd0, 8'd6);
    run("rst_p2", 1'b0, 3'd0, 8'd2);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_is_op = 1'b1; cmd_op = OP_DIV;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1 dc = done_cnt;
    rst_n = 1'b0;
    mq.delete();
    #1;
    chk("rst_exec", "count", count, 0);
    chk("rst_exec", "top", top, 0);
    chk("rst_exec", "err", err, 0);
    chk("rst_exec", "done", done, 0);
    chk("rst_exec", "alu_b", alu_b, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_exec", "no_done", done_cnt, dc);
    chk("rst_exec", "ready", cmd_ready, 1);
    chk("rst_exec", "count_after", count, 0);
    for (int i = 0; i < 300; i++) begin
      logic isop;
      logic [2:0] op;
      logic [7:0] d;
      isop = $urandom_range(0, 9) > 4;
      op = 3'($urandom_range(0, 7));
      d = $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom);
      run("rand", isop, op, d);
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
